// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the asynchronous FIFO, in the rdclk domain.
// It issues FIFO reads, captures the registered q one cycle later, and
// re-presents the words on a valid/ready stream through a 2-entry buffer.
// It also counts delivered words.
module fifo_rd_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             rdclk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_q,
  output logic             fifo_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_level,
  output logic [CNT_W-1:0] rd_cnt
);

  logic             inflight_q;
  logic [1:0]       level_q, level_d;
  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;
  logic [2:0]       occ;

  // Stream outputs and read request; occupancy counts words buffered plus in flight after a pop.
  always_comb begin
    out_valid = (level_q != 2'd0);
    out_data  = slot0_q;
    out_level = level_q;
    rd_cnt    = cnt_q;
    pop       = out_valid & out_ready;
    push      = inflight_q;
    // pop implies level_q >= 1, so this never underflows
    occ       = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd   = ~fifo_empty & (occ < 3'd2);
  end

  // Buffer, level and counter next-state.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case ({push, pop})
      2'b10: begin
        if (level_q == 2'd0) slot0_d = fifo_q;
        else                 slot1_d = fifo_q;
      end
      2'b01: begin
        if (level_q == 2'd2) slot0_d = slot1_q;
      end
      2'b11: begin
        if (level_q == 2'd1) begin
          slot0_d = fifo_q;
        end else begin
          slot0_d = slot1_q;
          slot1_d = fifo_q;
        end
      end
      default: ;
    endcase
    level_d = level_q + {1'b0, push} - {1'b0, pop};
    cnt_d   = cnt_q + CNT_W'(pop);
  end

  // State registers; a read in flight at reset is dropped with the FIFO.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      level_q    <= 2'd0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= fifo_rd;
      level_q    <= level_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, a
// scoreboard queue holds every word written, and a negedge monitor checks
// delivered data, occupancy, counters and the read/empty rules.
module tb_fifo_rd_stream;

  logic       rdclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_q = 8'h00;
  logic       fifo_rd;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_level;
  logic [15:0] rd_cnt;

  logic       fifo_rd4, out_valid4;
  logic [7:0] out_data4;
  logic [1:0] out_level4;
  logic [3:0] rd_cnt4;

  fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) dut (
    .rdclk(rdclk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rd(fifo_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_level(out_level), .rd_cnt(rd_cnt)
  );

  fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) dut4 (
    .rdclk(rdclk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rd(fifo_rd4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_level(out_level4), .rd_cnt(rd_cnt4)
  );

  always #5 rdclk = ~rdclk;

  logic [7:0] mem[$];    // FIFO contents model
  logic [7:0] exp_q[$];  // scoreboard: words in write order
  bit         rd_prev;
  int         nchk = 0;
  int         nerr = 0;
  int         n_rd = 0, n_valid = 0, n_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: occupancy bookkeeping from the rules, scoreboard pops, counters.
  int         lvl_m, infl_m;
  int unsigned cnt_m;
  bit         hold_m;
  logic [7:0] held_m;
  always @(negedge rdclk) begin
    if (!rst_n) begin
      lvl_m = 0; infl_m = 0; cnt_m = 0; hold_m = 0;
      chk("rd_in_reset_while_empty", 32'(fifo_rd & fifo_empty), 32'd0);
    end else begin
      chk("rd_while_empty", 32'(fifo_rd & fifo_empty), 32'd0);
      chk("level_plus_inflight_le2", 32'((32'(out_level) + 32'(infl_m)) <= 2), 32'd1);
      chk("out_level", 32'(out_level), 32'(lvl_m));
      chk("out_valid", 32'(out_valid), 32'(lvl_m != 0));
      chk("rd_cnt", 32'(rd_cnt), cnt_m & 32'hFFFF);
      chk("rd_cnt_w4", 32'(rd_cnt4), cnt_m & 32'hF);
      if (hold_m) chk("data_stable", 32'(out_data), 32'(held_m));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        cnt_m++;
        n_pop++;
      end
      hold_m = out_valid && !out_ready;
      held_m = out_data;
      if (fifo_rd) n_rd++;
      if (out_valid) n_valid++;
      lvl_m  = lvl_m + infl_m - ((out_valid && out_ready) ? 1 : 0);
      infl_m = fifo_rd;
    end
  end

  // One clock cycle: apply edge effects of the FIFO, then inputs, then sample at negedge.
  task automatic cycle(input bit wr, input logic [7:0] wd, input bit rdy);
    @(posedge rdclk);
    #1;
    if (rd_prev && mem.size() != 0) fifo_q = mem.pop_front();
    if (wr) begin
      mem.push_back(wd);
      exp_q.push_back(wd);
    end
    out_ready  = rdy;
    fifo_empty = (mem.size() == 0);
    @(negedge rdclk);
    rd_prev = fifo_rd;
    #1;
  endtask

  task automatic preload(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem.push_back(base + 8'(i));
      exp_q.push_back(base + 8'(i));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem.delete();
    exp_q.delete();
    rd_prev    = 1'b0;
    fifo_q     = 8'h00;
    fifo_empty = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_level", 32'(out_level), 32'd0);
    chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int rd0, vcount, vfirst, vlast, written, guard, pops0, prev4;
    bit seen_wrap, seen_one;

    // 1: single word
    do_reset();
    rd0 = n_rd; vcount = 0; vfirst = -1;
    for (int i = 0; i < 6; i++) begin
      cycle(i == 0, 8'hA5, 1'b1);
      if (out_valid) begin
        vcount++;
        if (vfirst < 0) vfirst = i;
      end
    end
    chk("t1_rd_pulses", 32'(n_rd - rd0), 32'd1);
    chk("t1_valid_cycles", 32'(vcount), 32'd1);
    chk("t1_first_valid_cycle", 32'(vfirst), 32'd2);
    chk("t1_rd_cnt", 32'(rd_cnt), 32'd1);

    // 2: eight preloaded words, always-ready sink
    do_reset();
    preload(8, 8'h00);
    vcount = 0; vfirst = -1; vlast = -1;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (out_valid) begin
        vcount++;
        if (vfirst < 0) vfirst = i;
        vlast = i;
      end
    end
    chk("t2_valid_cycles", 32'(vcount), 32'd8);
    chk("t2_contiguous", 32'(vlast - vfirst), 32'd7);
    chk("t2_rd_cnt", 32'(rd_cnt), 32'd8);
    chk("t2_level", 32'(out_level), 32'd0);
    chk("t2_valid_low", 32'(out_valid), 32'd0);

    // 3: back-pressure then release
    do_reset();
    preload(8, 8'h10);
    rd0 = n_rd;
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);
    chk("t3_rd_pulses", 32'(n_rd - rd0), 32'd2);
    chk("t3_level", 32'(out_level), 32'd2);
    chk("t3_head", 32'(out_data), 32'h10);
    vcount = 0; vfirst = -1; vlast = -1;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (out_valid && out_ready) begin
        vcount++;
        if (vfirst < 0) vfirst = i;
        vlast = i;
      end
    end
    chk("t3_pops", 32'(vcount), 32'd8);
    chk("t3_no_gap", 32'(vlast - vfirst), 32'd7);

    // 4: random writes and random ready
    do_reset();
    written = 0; guard = 0; pops0 = n_pop;
    while ((written < 200 || exp_q.size() != 0) && guard < 5000) begin
      if (written < 200 && $urandom_range(0, 1) == 1) begin
        cycle(1'b1, 8'($urandom), $urandom_range(0, 1) == 1);
        written++;
      end else begin
        cycle(1'b0, 8'h00, $urandom_range(0, 1) == 1);
      end
      guard++;
    end
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_delivered", 32'(n_pop - pops0), 32'd200);

    // 5: reset mid-burst with a full buffer and a read being issued
    do_reset();
    preload(6, 8'h30);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t5_pre_level", 32'(out_level), 32'd2);
    chk("t5_pre_rd", 32'(fifo_rd), 32'd1);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("t5_post_cnt", 32'(rd_cnt), 32'd3);
    chk("t5_post_drained", 32'(exp_q.size()), 32'd0);

    // 6: 4-bit counter wrap
    do_reset();
    preload(17, 8'h60);
    prev4 = 0; seen_wrap = 0; seen_one = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (prev4 == 15 && rd_cnt4 == 4'd0) seen_wrap = 1;
      if (seen_wrap && prev4 == 0 && rd_cnt4 == 4'd1) seen_one = 1;
      prev4 = int'(rd_cnt4);
    end
    chk("t6_wrap_15_to_0", 32'(seen_wrap), 32'd1);
    chk("t6_then_1", 32'(seen_one), 32'd1);
    chk("t6_final_cnt4", 32'(rd_cnt4), 32'd1);
    chk("t6_final_cnt16", 32'(rd_cnt), 32'd17);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
